// File: rtl/irq_pkg.sv
// Shared constants and helpers for the interrupt controller.
package irq_pkg;

    localparam int          NSRC    = 6;
    localparam logic [31:0] NONE_ID = 32'h3F;

    localparam logic [1:0] IRQ_PEND  = 2'd0;
    localparam logic [1:0] IRQ_MASK  = 2'd1;
    localparam logic [1:0] IRQ_MODE  = 2'd2;
    localparam logic [1:0] IRQ_CLAIM = 2'd3;

    // Lowest set index wins; empty vector yields NONE_ID.
    function automatic logic [31:0] prio_enc(input logic [NSRC-1:0] v);
        logic [31:0] r;
        r = NONE_ID;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) r = 32'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one interrupt line with rising-edge detect.
module irq_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic src_i,
    output logic level,
    output logic rise
);

    logic s1_q, s2_q, prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= src_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: capture, mask, priority and claim/EOI tracking
// behind a four-word register window.
module irq_ctrl
    import irq_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic [1:0]      addr,
    input  logic            we,
    input  logic            re,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic [NSRC-1:0] hwint,
    output logic            irq
);

    logic [NSRC-1:0] level, rise;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] insv_q, insv_d;
    logic [NSRC-1:0] elig;
    logic [31:0]     claim_id;
    logic            wr_pend, wr_mask, wr_mode, eoi, claim_fire;
    logic            unused_wdata;

    for (genvar g = 0; g < NSRC; g++) begin : g_sync
        irq_sync_edge u_sync (
            .clk   (clk),
            .rst_n (reset),
            .src_i (src[g]),
            .level (level[g]),
            .rise  (rise[g])
        );
    end

    // An in-service source blocks itself and everything of lower priority.
    always_comb begin : p_elig
        logic blk;
        blk  = 1'b0;
        elig = '0;
        for (int i = 0; i < NSRC; i++) begin
            blk     = blk | insv_q[i];
            elig[i] = pend_q[i] & mask_q[i] & ~blk;
        end
    end

    assign claim_id   = prio_enc(elig);
    assign wr_pend    = we & (addr == IRQ_PEND);
    assign wr_mask    = we & (addr == IRQ_MASK);
    assign wr_mode    = we & (addr == IRQ_MODE);
    assign eoi        = we & (addr == IRQ_CLAIM);
    assign claim_fire = re & ~we & (addr == IRQ_CLAIM)
                        & (claim_id != NONE_ID);

    always_comb begin
        mask_d = wr_mask ? wdata[NSRC-1:0] : mask_q;
        mode_d = wr_mode ? wdata[NSRC-1:0] : mode_q;
        pend_d = pend_q;
        insv_d = insv_q;
        for (int i = 0; i < NSRC; i++) begin
            if (claim_fire && claim_id == 32'(i)) insv_d[i] = 1'b1;
            if (eoi && {27'd0, wdata[4:0]} == 32'(i)) insv_d[i] = 1'b0;
            if (mode_q[i]) begin
                if (wr_pend && wdata[i]) pend_d[i] = 1'b0;
                if (claim_fire && claim_id == 32'(i)) pend_d[i] = 1'b0;
                if (rise[i]) pend_d[i] = 1'b1;
            end else begin
                pend_d[i] = level[i];
            end
            if (wr_mode && wdata[i] != mode_q[i]) pend_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
            mask_q <= '0;
            mode_q <= '0;
            insv_q <= '0;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
            mode_q <= mode_d;
            insv_q <= insv_d;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (addr)
            IRQ_PEND:  rdata = 32'(pend_q);
            IRQ_MASK:  rdata = 32'(mask_q);
            IRQ_MODE:  rdata = 32'(mode_q);
            IRQ_CLAIM: rdata = claim_id;
        endcase
    end

    assign hwint        = elig;
    assign irq          = |elig;
    assign unused_wdata = ^wdata[31:NSRC];

endmodule
